// File: rtl/icache.sv
// Direct-mapped instruction cache with 4-word lines, one-cycle hit latency
// and a single-request refill path to memory. Flush (fence.i) clears all
// valid bits; a flush arriving mid-refill is deferred until the refill ends.
module icache #(
  parameter int LINES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ic_req_valid,
  input  logic [31:0] ic_req_addr,
  output logic        ic_req_ready,
  output logic        ic_rsp_valid,
  output logic [31:0] ic_rsp_data,
  input  logic        flush_i,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, REFILL} state_t;

  state_t           state_r;
  state_t           state_s;
  logic [31:2]      addr_r;
  logic [1:0]       beat_r;
  logic             flush_pend_r;
  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [31:0]      data_r [LINES][4];

  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic [1:0]       off_s;
  logic             hit_s;
  logic             accept_s;
  logic             last_beat_s;
  logic             flush_now_s;
  logic             unused_s;

  // Byte-select bits never affect a word fetch.
  assign unused_s = ^ic_req_addr[1:0];

  // Address decode of the captured request, hit detection and handshake terms.
  always_comb begin
    idx_s       = addr_r[4 +: IDX_W];
    tag_s       = addr_r[31 -: TAG_W];
    off_s       = addr_r[3:2];
    hit_s       = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    accept_s    = ic_req_valid && ic_req_ready;
    last_beat_s = (state_r == REFILL) && mem_rsp_valid && (beat_r == 2'd3);
    flush_now_s = flush_i || flush_pend_r;
  end

  // State register; reset drops any refill in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:     if (accept_s) state_s = LOOKUP; else state_s = IDLE;
      LOOKUP: begin
        if (hit_s) begin
          if (accept_s) state_s = LOOKUP; else state_s = IDLE;
        end else begin
          state_s = MISS_REQ;
        end
      end
      MISS_REQ: if (mem_req_ready) state_s = REFILL; else state_s = MISS_REQ;
      REFILL: begin
        if (last_beat_s) begin
          // With a deferred flush the response comes straight from the refill.
          if (flush_now_s) state_s = IDLE; else state_s = LOOKUP;
        end else begin
          state_s = REFILL;
        end
      end
      default:  state_s = IDLE;
    endcase
  end

  // Output decode; everything is held at zero while reset is asserted.
  always_comb begin
    ic_req_ready  = 1'b0;
    ic_rsp_valid  = 1'b0;
    ic_rsp_data   = 32'h0;
    mem_req_valid = 1'b0;
    mem_req_addr  = 32'h0;
    if (rst_i) begin
      ic_req_ready = 1'b0;
    end else begin
      ic_req_ready = !flush_i && ((state_r == IDLE) || ((state_r == LOOKUP) && hit_s));
      if ((state_r == LOOKUP) && hit_s) begin
        ic_rsp_valid = 1'b1;
        ic_rsp_data  = data_r[idx_s][off_s];
      end else if (last_beat_s && flush_now_s) begin
        // The final beat is not in the array yet, so forward it directly.
        ic_rsp_valid = 1'b1;
        ic_rsp_data  = (off_s == 2'd3) ? mem_rsp_data : data_r[idx_s][off_s];
      end else begin
        ic_rsp_valid = 1'b0;
      end
      if (state_r == MISS_REQ) begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_r[31:4], 4'h0};
      end else begin
        mem_req_valid = 1'b0;
      end
    end
  end

  // Request address capture, beat counter and deferred-flush flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_r       <= 30'h0;
      beat_r       <= 2'd0;
      flush_pend_r <= 1'b0;
    end else begin
      if (accept_s) addr_r <= ic_req_addr[31:2];
      if (state_r == MISS_REQ) beat_r <= 2'd0;
      else if ((state_r == REFILL) && mem_rsp_valid) beat_r <= beat_r + 2'd1;
      if (last_beat_s) flush_pend_r <= 1'b0;
      else if (flush_i && ((state_r == MISS_REQ) || (state_r == REFILL))) flush_pend_r <= 1'b1;
    end
  end

  // Valid bits: cleared by flush or reset, set when a refill completes cleanly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= '0;
    end else if ((flush_i && ((state_r == IDLE) || (state_r == LOOKUP))) ||
                 (last_beat_s && flush_now_s)) begin
      valid_r <= '0;
    end else if (last_beat_s) begin
      valid_r[idx_s] <= 1'b1;
    end
  end

  // Line data and tag storage; contents are meaningless until valid is set.
  always_ff @(posedge clk_i) begin
    if ((state_r == REFILL) && mem_rsp_valid) begin
      data_r[idx_s][beat_r] <= mem_rsp_data;
      if (beat_r == 2'd3) tag_r[idx_s] <= tag_s;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache (LINES=16). Inputs are driven on the falling
// edge and outputs sampled 1 time unit later.
module tb_icache;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_rsp_valid;
  logic [31:0] ic_rsp_data;
  logic        flush_i;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  int n_cmp = 0;
  int n_err = 0;
  int rsp_cnt = 0;
  int memv_cnt = 0;
  int b_rsp;
  int b_mem;

  icache #(.LINES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .flush_i(flush_i),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk_i = ~clk_i;

  // Count response pulses and memory-request cycles.
  always @(negedge clk_i) begin
    #2;
    if (ic_rsp_valid === 1'b1) rsp_cnt++;
    if (mem_req_valid === 1'b1) memv_cnt++;
  end

  // Drive four refill beats base+0..3, pulsing flush on beat index fl.
  task send_beats(input logic [31:0] base, input int fl);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk_i);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = base + i;
      flush_i       = (i == fl);
    end
  endtask

  task test_reset;
    @(negedge clk_i);
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1008;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55;
    #1;
    n_cmp++; if (ic_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", ic_req_ready); end
    n_cmp++; if (ic_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", ic_rsp_valid); end
    n_cmp++; if (ic_rsp_data !== 32'h0) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0", ic_rsp_data); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_mem_valid: got %b want 0", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_req_addr); end
    @(negedge clk_i);
    ic_req_valid = 1'b0; mem_rsp_valid = 1'b0; rst_i = 1'b0;
    #1;
    n_cmp++; if (ic_req_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", ic_req_ready); end
  endtask

  task test_cold_miss;
    b_rsp = rsp_cnt; b_mem = memv_cnt;
    @(negedge clk_i); ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1008;
    @(negedge clk_i); ic_req_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b0) begin n_err++; $display("FAIL cold_lookup_rsp: got %b want 0", ic_rsp_valid); end
    n_cmp++; if (ic_req_ready !== 1'b0) begin n_err++; $display("FAIL cold_lookup_ready: got %b want 0", ic_req_ready); end
    @(negedge clk_i); #1;
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL cold_mem_valid: got %b want 1", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 32'h0000_1000) begin n_err++; $display("FAIL cold_mem_addr: got %h want 00001000", mem_req_addr); end
    mem_req_ready = 1'b1;
    @(negedge clk_i); mem_req_ready = 1'b0;
    send_beats(32'hA0, 4);
    @(negedge clk_i); mem_rsp_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b1) begin n_err++; $display("FAIL cold_rsp_valid: got %b want 1", ic_rsp_valid); end
    n_cmp++; if (ic_rsp_data !== 32'hA2) begin n_err++; $display("FAIL cold_rsp_data: got %h want a2", ic_rsp_data); end
    @(negedge clk_i); #3;
    n_cmp++; if (rsp_cnt - b_rsp !== 1) begin n_err++; $display("FAIL cold_rsp_count: got %0d want 1", rsp_cnt - b_rsp); end
    n_cmp++; if (memv_cnt - b_mem !== 1) begin n_err++; $display("FAIL cold_mem_count: got %0d want 1", memv_cnt - b_mem); end
  endtask

  task test_back_to_back;
    b_rsp = rsp_cnt; b_mem = memv_cnt;
    @(negedge clk_i); ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1000;
    @(negedge clk_i); ic_req_addr = 32'h0000_1004; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== 32'hA0) begin n_err++; $display("FAIL b2b_0: got %b/%h want 1/a0", ic_rsp_valid, ic_rsp_data); end
    n_cmp++; if (ic_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", ic_req_ready); end
    @(negedge clk_i); ic_req_addr = 32'h0000_100C; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== 32'hA1) begin n_err++; $display("FAIL b2b_1: got %b/%h want 1/a1", ic_rsp_valid, ic_rsp_data); end
    @(negedge clk_i); ic_req_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== 32'hA3) begin n_err++; $display("FAIL b2b_2: got %b/%h want 1/a3", ic_rsp_valid, ic_rsp_data); end
    @(negedge clk_i); #3;
    n_cmp++; if (ic_rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_rsp: got %b want 0", ic_rsp_valid); end
    n_cmp++; if (rsp_cnt - b_rsp !== 3) begin n_err++; $display("FAIL b2b_rsp_count: got %0d want 3", rsp_cnt - b_rsp); end
    n_cmp++; if (memv_cnt !== b_mem) begin n_err++; $display("FAIL b2b_mem_count: got %0d want %0d", memv_cnt, b_mem); end
  endtask

  task test_conflict;
    @(negedge clk_i); ic_req_valid = 1'b1; ic_req_addr = 32'h0000_2008;
    @(negedge clk_i); ic_req_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b0) begin n_err++; $display("FAIL conf_miss: got %b want 0", ic_rsp_valid); end
    @(negedge clk_i); #1;
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_2000) begin n_err++; $display("FAIL conf_mem: got %b/%h want 1/00002000", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1;
    @(negedge clk_i); mem_req_ready = 1'b0;
    send_beats(32'hB0, 4);
    @(negedge clk_i); mem_rsp_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== 32'hB2) begin n_err++; $display("FAIL conf_rsp: got %b/%h want 1/b2", ic_rsp_valid, ic_rsp_data); end
    @(negedge clk_i); ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1008;
    @(negedge clk_i); ic_req_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b0) begin n_err++; $display("FAIL conf_remiss: got %b want 0", ic_rsp_valid); end
    @(negedge clk_i); #1;
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1000) begin n_err++; $display("FAIL conf_remem: got %b/%h want 1/00001000", mem_req_valid, mem_req_addr); end
  endtask

  task test_mem_stall;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); ic_req_valid = 1'b1; ic_req_addr = 32'h0000_5000; #1;
      n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1000) begin n_err++; $display("FAIL stall_mem_%0d: got %b/%h want 1/00001000", i, mem_req_valid, mem_req_addr); end
      n_cmp++; if (ic_req_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_%0d: got %b want 0", i, ic_req_ready); end
    end
    ic_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk_i); mem_req_ready = 1'b0;
    send_beats(32'hA0, 4);
    @(negedge clk_i); mem_rsp_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== 32'hA2) begin n_err++; $display("FAIL stall_rsp: got %b/%h want 1/a2", ic_rsp_valid, ic_rsp_data); end
  endtask

  task test_flush_refill;
    @(negedge clk_i); b_rsp = rsp_cnt; ic_req_valid = 1'b1; ic_req_addr = 32'h0000_3004;
    @(negedge clk_i); ic_req_valid = 1'b0;
    @(negedge clk_i); #1;
    n_cmp++; if (mem_req_addr !== 32'h0000_3000) begin n_err++; $display("FAIL fr_mem_addr: got %h want 00003000", mem_req_addr); end
    mem_req_ready = 1'b1;
    @(negedge clk_i); mem_req_ready = 1'b0;
    send_beats(32'hC0, 1);
    #1;
    n_cmp++; if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== 32'hC1) begin n_err++; $display("FAIL fr_rsp: got %b/%h want 1/c1", ic_rsp_valid, ic_rsp_data); end
    @(negedge clk_i); mem_rsp_valid = 1'b0; #1;
    n_cmp++; if (ic_req_ready !== 1'b1 || ic_rsp_valid !== 1'b0) begin n_err++; $display("FAIL fr_idle: got ready %b rsp %b want 1 0", ic_req_ready, ic_rsp_valid); end
    #2;
    n_cmp++; if (rsp_cnt - b_rsp !== 1) begin n_err++; $display("FAIL fr_rsp_count: got %0d want 1", rsp_cnt - b_rsp); end
    @(negedge clk_i); ic_req_valid = 1'b1; ic_req_addr = 32'h0000_3004;
    @(negedge clk_i); ic_req_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b0) begin n_err++; $display("FAIL fr_remiss: got %b want 0", ic_rsp_valid); end
    @(negedge clk_i); #1;
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL fr_remem: got %b want 1", mem_req_valid); end
    mem_req_ready = 1'b1;
    @(negedge clk_i); mem_req_ready = 1'b0;
    send_beats(32'hD0, 4);
    @(negedge clk_i); mem_rsp_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== 32'hD1) begin n_err++; $display("FAIL fr_refill_rsp: got %b/%h want 1/d1", ic_rsp_valid, ic_rsp_data); end
  endtask

  task test_flush_hit;
    @(negedge clk_i); ic_req_valid = 1'b1; ic_req_addr = 32'h0000_3008;
    @(negedge clk_i); ic_req_valid = 1'b0; flush_i = 1'b1; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== 32'hD2) begin n_err++; $display("FAIL fh_rsp: got %b/%h want 1/d2", ic_rsp_valid, ic_rsp_data); end
    n_cmp++; if (ic_req_ready !== 1'b0) begin n_err++; $display("FAIL fh_ready: got %b want 0", ic_req_ready); end
    @(negedge clk_i); flush_i = 1'b0; #1;
    n_cmp++; if (ic_req_ready !== 1'b1) begin n_err++; $display("FAIL fh_idle: got %b want 1", ic_req_ready); end
    @(negedge clk_i); ic_req_valid = 1'b1; ic_req_addr = 32'h0000_3008;
    @(negedge clk_i); ic_req_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b0) begin n_err++; $display("FAIL fh_miss: got %b want 0", ic_rsp_valid); end
    @(negedge clk_i); #1;
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_3000) begin n_err++; $display("FAIL fh_mem: got %b/%h want 1/00003000", mem_req_valid, mem_req_addr); end
  endtask

  task test_reset_refill;
    mem_req_ready = 1'b1;
    @(negedge clk_i); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hE0;
    @(negedge clk_i); mem_rsp_data = 32'hE1; rst_i = 1'b1; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b0 || ic_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rr_in_reset: got rsp %b rdy %b mem %b want 0 0 0", ic_rsp_valid, ic_req_ready, mem_req_valid); end
    @(negedge clk_i); rst_i = 1'b0; mem_rsp_data = 32'hE2; #1;
    n_cmp++; if (ic_req_ready !== 1'b1) begin n_err++; $display("FAIL rr_ready: got %b want 1", ic_req_ready); end
    @(negedge clk_i); mem_rsp_data = 32'hE3; ic_req_valid = 1'b1; ic_req_addr = 32'h0000_3008;
    @(negedge clk_i); mem_rsp_valid = 1'b0; ic_req_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_miss: got %b want 0", ic_rsp_valid); end
    @(negedge clk_i); #1;
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_3000) begin n_err++; $display("FAIL rr_mem: got %b/%h want 1/00003000", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1;
    @(negedge clk_i); mem_req_ready = 1'b0;
    send_beats(32'hF0, 4);
    @(negedge clk_i); mem_rsp_valid = 1'b0; #1;
    n_cmp++; if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== 32'hF2) begin n_err++; $display("FAIL rr_rsp: got %b/%h want 1/f2", ic_rsp_valid, ic_rsp_data); end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; ic_req_valid = 1'b0; ic_req_addr = 32'h0; flush_i = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    test_reset;
    test_cold_miss;
    test_back_to_back;
    test_conflict;
    test_mem_stall;
    test_flush_refill;
    test_flush_hit;
    test_reset_refill;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of two, 2..256); line size fixed at 4 words (16 bytes).
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ic_req_valid  input  1  fetch requests an instruction.
REQ-005 SHALL have port ic_req_addr  input  32  byte address of the requested instruction; bits [1:0] ignored.
REQ-006 SHALL have port ic_req_ready  output  1  cache accepts the request this cycle.
REQ-007 SHALL have port ic_rsp_valid  output  1  ic_rsp_data is valid; one-cycle pulse per accepted request, with no backpressure.
REQ-008 SHALL have port ic_rsp_data  output  32  instruction word.
REQ-009 SHALL have port flush_i  input  1  invalidate all lines (fence.i).
REQ-010 SHALL have port mem_req_valid  output  1  line refill request to memory.
REQ-011 SHALL have port mem_req_ready  input  1  memory accepts the refill request.
REQ-012 SHALL have port mem_req_addr  output  32  line-aligned refill address.
REQ-013 SHALL have port mem_rsp_valid  input  1  one refill beat is present.
REQ-014 SHALL have port mem_rsp_data  input  32  refill beat data.

Function
REQ-015 SHALL decode the address as: word offset = addr[3:2]; index = addr[4+log2(LINES)-1:4]; tag = the remaining upper bits.
REQ-016 SHALL implement states IDLE, LOOKUP, MISS_REQ and REFILL.
REQ-017 SHALL accept a request when ic_req_valid && ic_req_ready, capture the address, and enter LOOKUP on the next cycle.
REQ-018 SHALL drive ic_req_ready=1 in IDLE and in a LOOKUP hit cycle, and 0 in MISS_REQ, in REFILL, in a LOOKUP miss cycle, and in any cycle where flush_i=1.
REQ-019 On a LOOKUP hit (line valid and tag equal), SHALL assert ic_rsp_valid with the addressed word in that same cycle, giving 1-cycle hit latency.
REQ-020 After a LOOKUP hit, SHALL go to LOOKUP if a new request is accepted in the same cycle, otherwise to IDLE, sustaining 1 response per cycle on consecutive hits.
REQ-021 On a LOOKUP miss, SHALL keep ic_rsp_valid=0 and go to MISS_REQ.
REQ-022 In MISS_REQ, SHALL hold mem_req_valid=1 with mem_req_addr={addr[31:4],4'h0}, stable until mem_req_ready=1, then go to REFILL.
REQ-023 In REFILL, SHALL write mem_rsp_data into line words 0,1,2,3 in beat order on each mem_rsp_valid, using a 2-bit beat counter.
REQ-024 On the 4th beat, SHALL write the tag and set the valid bit, then go to LOOKUP with the captured address; the replay hits and responds.
REQ-025 SHALL ignore mem_rsp_valid outside REFILL.
REQ-026 In IDLE or LOOKUP, flush_i=1 SHALL clear all valid bits at the next edge.
REQ-027 A LOOKUP hit coinciding with flush_i SHALL still deliver its response.
REQ-028 flush_i during MISS_REQ or REFILL SHALL be recorded as pending.
REQ-029 With a flush pending, the refill SHALL complete and respond to the requester once directly from the refilled line (not by replay); all valid bits SHALL then clear and the state SHALL return to IDLE.
REQ-030 SHALL produce exactly one response per accepted request, in acceptance order.

Reset
REQ-031 While rst_i=1, SHALL force state=IDLE, all valid bits=0, beat counter=0 and pending flush=0.
REQ-032 While rst_i=1, SHALL drive ic_req_ready=0, ic_rsp_valid=0, ic_rsp_data=0, mem_req_valid=0 and mem_req_addr=0.
REQ-033 Reset asserted mid-refill SHALL discard the partial line (valid stays 0), and any later beats SHALL be ignored.
REQ-034 On the first cycle after reset, SHALL drive ic_req_ready=1.

Verification
REQ-035 Cold miss: request 0x0000_1008 -> mem_req_addr=0x0000_1000; beats 0xA0,0xA1,0xA2,0xA3 -> single ic_rsp_valid with data 0xA2.
REQ-036 Back-to-back hits: after REQ-035, requests 0x1000,0x1004,0x100C on consecutive cycles -> ic_rsp_valid on 3 consecutive cycles with data 0xA0,0xA1,0xA3; no memory request.
REQ-037 Conflict miss (LINES=16): request 0x0000_2008 (same index, new tag) -> refill from 0x2000; a following request to 0x1008 misses again.
REQ-038 Memory stall: mem_req_ready low for 5 cycles -> mem_req_valid and mem_req_addr stable throughout, ic_req_ready=0.
REQ-039 Flush during refill: flush_i pulse at beat 2 -> requester still gets correct word; the next request to the same line misses.
REQ-040 Reset mid-refill: rst_i after beat 1, then request the same address -> fresh mem_req issued; stale beats are ignored.
